muldiv_ctrl: RTL and testbench

- Sequences the HI/LO multiply/divide resource behind the EX stage of the mipsel32 pipeline. Owns the HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from EX and runs multi-cycle multiply and iterative divide.
- Produces the busy/stall signal consumed by pipeline hazard logic, so younger HI/LO users wait until results are committed.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/div_iter.sv | 53 +++++
 rtl/muldiv_ctrl.sv | 169 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encoding, FSM states and divide width for the HI/LO muldiv unit
package muldiv_pkg;

   localparam int DIV_BITS = 32;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MFHI  = 4'd7,
      OP_MFLO  = 4'd8
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } muldiv_state_t;

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - restoring unsigned divider, one quotient bit per step
module div_iter
   import muldiv_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                step,
   input  logic [DIV_BITS-1:0] dividend,
   input  logic [DIV_BITS-1:0] divisor,
   output logic [DIV_BITS-1:0] quotient,
   output logic [DIV_BITS-1:0] remainder
);

   logic [DIV_BITS-1:0] rem_q, rem_d;
   logic [DIV_BITS-1:0] quot_q, quot_d;
   logic [DIV_BITS-1:0] dsr_q, dsr_d;
   logic [DIV_BITS:0]   shifted;
   logic                fits;

   always_comb begin
      rem_d   = rem_q;
      quot_d  = quot_q;
      dsr_d   = dsr_q;
      shifted = {rem_q, quot_q[DIV_BITS-1]};
      fits    = shifted >= {1'b0, dsr_q};
      if (load) begin
         rem_d  = '0;
         quot_d = dividend;
         dsr_d  = divisor;
      end else if (step) begin
         // when the subtraction fits, the true difference is below 2^32, so modular math is exact
         rem_d  = fits ? (shifted[DIV_BITS-1:0] - dsr_q) : shifted[DIV_BITS-1:0];
         quot_d = {quot_q[DIV_BITS-2:0], fits};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem_q  <= '0;
         quot_q <= '0;
         dsr_q  <= '0;
      end else begin
         rem_q  <= rem_d;
         quot_q <= quot_d;
         dsr_q  <= dsr_d;
      end
   end

   assign quotient  = quot_q;
   assign remainder = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide sequencer and stall source for EX
// Optional divide early-out enabled by defining MULDIV_DIV_EARLY_OUT_EN.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int MUL_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [3:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        flush_EX,
   input  logic        ex_stall,
   output logic        hilo_stall,
   output logic        busy,
   output logic [31:0] mf_data,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   muldiv_state_t state_q, state_d;
   muldiv_op_t    op_e;
   logic [4:0]    cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d;
   logic          mul_signed_q, mul_signed_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
   logic          op_live, accept, div_load, div_step;
   logic [31:0]   abs_a, abs_b, quot, rem;
   logic [63:0]   product;
`ifdef MULDIV_DIV_EARLY_OUT_EN
   logic          eo_q, eo_d;
`endif

   assign op_e    = muldiv_op_t'(op);
   assign op_live = op_valid && (op_e != OP_NONE);
   assign busy    = (state_q != ST_IDLE);
   assign accept  = op_live && !flush_EX && !ex_stall && !busy;
   assign abs_a   = (op_e == OP_DIV && rs_data[31]) ? -rs_data : rs_data;
   assign abs_b   = (op_e == OP_DIV && rt_data[31]) ? -rt_data : rt_data;
   // low 64 bits of the extended product are the same for signed and unsigned operands
   assign product = {{32{mul_signed_q & a_q[31]}}, a_q} * {{32{mul_signed_q & b_q[31]}}, b_q};

   div_iter u_div_iter (
      .clk       (clk),
      .reset     (reset),
      .load      (div_load),
      .step      (div_step),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .quotient  (quot),
      .remainder (rem)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      a_d          = a_q;
      b_d          = b_q;
      mul_signed_d = mul_signed_q;
      q_neg_d      = q_neg_q;
      r_neg_d      = r_neg_q;
      div_load     = 1'b0;
      div_step     = 1'b0;
`ifdef MULDIV_DIV_EARLY_OUT_EN
      eo_d         = eo_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (op_e)
                  OP_MULT, OP_MULTU: begin
                     a_d          = rs_data;
                     b_d          = rt_data;
                     mul_signed_d = (op_e == OP_MULT);
                     cnt_d        = '0;
                     state_d      = ST_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     a_d      = rs_data;
                     b_d      = rt_data;
                     q_neg_d  = (op_e == OP_DIV) && (rs_data[31] ^ rt_data[31]);
                     r_neg_d  = (op_e == OP_DIV) && rs_data[31];
                     div_load = 1'b1;
                     cnt_d    = '0;
                     state_d  = ST_DIV;
`ifdef MULDIV_DIV_EARLY_OUT_EN
                     eo_d = 1'b0;
                     if (rt_data == '0 || (op_e == OP_DIVU && rs_data < rt_data)) begin
                        eo_d    = 1'b1;
                        state_d = ST_FIX;
                     end
`endif
                  end
                  OP_MTHI: hi_d = rs_data;
                  OP_MTLO: lo_d = rs_data;
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(MUL_CYCLES - 1)) begin
               {hi_d, lo_d} = product;
               cnt_d        = '0;
               state_d      = ST_IDLE;
            end
         end
         ST_DIV: begin
            div_step = 1'b1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_BITS - 1)) begin
               cnt_d   = '0;
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            lo_d    = q_neg_q ? -quot : quot;
            hi_d    = r_neg_q ? -rem : rem;
            state_d = ST_IDLE;
`ifdef MULDIV_DIV_EARLY_OUT_EN
            if (eo_q) begin
               lo_d = (b_q == '0) ? 32'hFFFF_FFFF : 32'h0;
               hi_d = a_q;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         mul_signed_q <= 1'b0;
         q_neg_q      <= 1'b0;
         r_neg_q      <= 1'b0;
`ifdef MULDIV_DIV_EARLY_OUT_EN
         eo_q         <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         a_q          <= a_d;
         b_q          <= b_d;
         mul_signed_q <= mul_signed_d;
         q_neg_q      <= q_neg_d;
         r_neg_q      <= r_neg_d;
`ifdef MULDIV_DIV_EARLY_OUT_EN
         eo_q         <= eo_d;
`endif
      end
   end

   assign hilo_stall = op_live && busy;
   assign mf_data    = (op_e == OP_MFHI) ? hi_q : (op_e == OP_MFLO) ? lo_q : 32'h0;
   assign hi         = hi_q;
   assign lo         = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed and randomized checks of muldiv_ctrl against an arithmetic model
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        reset, op_valid, flush_EX, ex_stall;
   logic [3:0]  op;
   logic [31:0] rs_data, rt_data;
   logic        hilo_stall, busy;
   logic [31:0] mf_data, hi, lo;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_hi = 32'h0;
   logic [31:0] m_lo = 32'h0;

   muldiv_ctrl #(.MUL_CYCLES(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .op_valid   (op_valid),
      .op         (op),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .flush_EX   (flush_EX),
      .ex_stall   (ex_stall),
      .hilo_stall (hilo_stall),
      .busy       (busy),
      .mf_data    (mf_data),
      .hi         (hi),
      .lo         (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // architectural result of one op, from the instruction definitions
   task automatic model(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         OP_MULT:  {m_hi, m_lo} = 64'(sa * sb);
         OP_MULTU: {m_hi, m_lo} = {32'd0, a} * {32'd0, b};
         OP_DIV: begin
            if (b == 32'd0) begin
               m_lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
               m_hi = a;
            end else begin
               m_lo = 32'(sa / sb);
               m_hi = 32'(sa % sb);
            end
         end
         OP_DIVU: begin
            if (b == 32'd0) begin
               m_lo = 32'hFFFF_FFFF;
               m_hi = a;
            end else begin
               m_lo = a / b;
               m_hi = a % b;
            end
         end
         OP_MTHI: m_hi = a;
         OP_MTLO: m_lo = a;
         default: ;
      endcase
   endtask

   task automatic drive(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic fl, input logic st);
      @(negedge clk);
      op_valid = 1'b1;
      op       = o;
      rs_data  = a;
      rt_data  = b;
      flush_EX = fl;
      ex_stall = st;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op       = OP_NONE;
      flush_EX = 1'b0;
      ex_stall = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_stall(output int n);
      n = 0;
      @(negedge clk);
      while (hilo_stall && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run(input string tag, input muldiv_op_t o, input logic [31:0] a,
                      input logic [31:0] b, input int exp_busy);
      int n;
      drive(o, a, b, 1'b0, 1'b0);
      model(o, a, b);
      wait_idle(n);
      check({tag, " busy_cycles"}, 32'(n), 32'(exp_busy));
      check({tag, " hi"}, hi, m_hi);
      check({tag, " lo"}, lo, m_lo);
   endtask

   initial begin
      int n;
      reset    = 1'b1;
      op_valid = 1'b0;
      op       = OP_NONE;
      rs_data  = '0;
      rt_data  = '0;
      flush_EX = 1'b0;
      ex_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset hilo_stall", 32'(hilo_stall), 32'd0);
      check("reset hi", hi, 32'h0);
      check("reset lo", lo, 32'h0);
      reset = 1'b0;

      run("mult -2*3", OP_MULT, 32'hFFFF_FFFE, 32'd3, 2);
      check("mult literal hi", hi, 32'hFFFF_FFFF);
      check("mult literal lo", lo, 32'hFFFF_FFFA);
      run("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 2);
      check("multu literal hi", hi, 32'h2);

      // DIV -7/2 with an MFLO waiting behind it
      drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      model(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      op_valid = 1'b1;
      op       = OP_MFLO;
      wait_stall(n);
      check("div mflo stall_cycles", 32'(n), 32'd33);
      check("div mflo busy", 32'(busy), 32'd0);
      check("div mflo mf_data", mf_data, 32'hFFFF_FFFD);
      check("div hi", hi, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op       = OP_NONE;

      run("divu by zero", OP_DIVU, 32'd5, 32'd0, 33);
      check("divu0 literal lo", lo, 32'hFFFF_FFFF);
      check("divu0 literal hi", hi, 32'd5);

      drive(OP_MULT, 32'd5, 32'd6, 1'b1, 1'b0);
      @(negedge clk);
      check("flushed mult busy", 32'(busy), 32'd0);
      check("flushed mult hi", hi, m_hi);
      check("flushed mult lo", lo, m_lo);

      drive(OP_MTHI, 32'h1234, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      check("stalled mthi hi", hi, m_hi);
      run("mthi", OP_MTHI, 32'h1234, 32'd0, 0);
      check("mthi literal hi", hi, 32'h1234);

      // DIV overflow case with an MTLO queued behind it
      drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      op_valid = 1'b1;
      op       = OP_MTLO;
      rs_data  = 32'h0000_ABCD;
      wait_stall(n);
      check("div ovf stall_cycles", 32'(n), 32'd33);
      check("div ovf lo", lo, 32'h8000_0000);
      check("div ovf hi", hi, 32'h0);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op       = OP_NONE;
      m_hi = 32'h0;
      m_lo = 32'h0000_ABCD;
      @(negedge clk);
      check("queued mtlo lo", lo, m_lo);

      // reset in the middle of a divide
      drive(OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      check("mid div busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_hi = 32'h0;
      m_lo = 32'h0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort hi", hi, 32'h0);
      check("abort lo", lo, 32'h0);
      run("mult 3*4", OP_MULT, 32'd3, 32'd4, 2);
      check("mult 3*4 literal lo", lo, 32'd12);

      for (int i = 0; i < 40; i++) begin
         muldiv_op_t  o;
         logic [31:0] a, b;
         int          eb;
         case ($urandom_range(0, 5))
            0:       o = OP_MULT;
            1:       o = OP_MULTU;
            2:       o = OP_DIV;
            3:       o = OP_DIVU;
            4:       o = OP_MTHI;
            default: o = OP_MTLO;
         endcase
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         eb = (o == OP_MULT || o == OP_MULTU) ? 2 : (o == OP_DIV || o == OP_DIVU) ? 33 : 0;
         run($sformatf("rnd%0d op%0d a=%h b=%h", i, o, a, b), o, a, b, eb);
         @(negedge clk);
         op_valid = 1'b1;
         op       = OP_MFHI;
         #1;
         check("rnd mfhi", mf_data, m_hi);
         op = OP_MFLO;
         #1;
         check("rnd mflo", mf_data, m_lo);
         op_valid = 1'b0;
         op       = OP_NONE;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
